puf_measure_ctrl: RTL and testbench

Sequencer for the ring-oscillator PUF measurement datapath. It drives a pair of 8-bit enable/reset up counters, one per oscillator of the selected pair. For each response bit it selects an oscillator pair, clears both counters, gates them for a programmable window, compares the final counts and records the response bit. It sits between the host or challenge logic and the counter/RO-mux datapath.

---
 rtl/puf_ctrl_pkg.sv | 22 ++
 rtl/puf_win_timer.sv | 27 ++
 rtl/puf_measure_ctrl.sv | 158 +++++++++++++++
 tb/tb_puf_measure_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/puf_ctrl_pkg.sv
// Shared types and helpers for the ring-oscillator PUF measurement sequencer.
package puf_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    localparam int unsigned CNT_W_DEF     = 8;
    localparam int unsigned WIN_W_DEF     = 16;
    localparam int unsigned RESP_BITS_DEF = 8;

    // A zero-length window would never reach the last-cycle marker, so it runs as one cycle.
    function automatic int unsigned win_coerce(input int unsigned len);
        return (len == 0) ? 1 : len;
    endfunction

endpackage

// File: rtl/puf_win_timer.sv
// Measurement-window down counter: loaded with the window length, flags its final cycle.
module puf_win_timer #(
    parameter int unsigned WIN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIN_W-1:0] len,
    input  logic             dec,
    output logic             last
);

    logic [WIN_W-1:0] r_win_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_win_cnt <= '0;
        end else if (load) begin
            r_win_cnt <= len;
        end else if (dec && (r_win_cnt != '0)) begin
            r_win_cnt <= r_win_cnt - WIN_W'(1);
        end
    end

    assign last = (r_win_cnt == WIN_W'(1));

endmodule

// File: rtl/puf_measure_ctrl.sv
// RO-PUF measurement sequencer: per bit clear, gate, settle and compare an oscillator pair.
// Optional per-bit tie flags are built when PUF_TIE_FLAG_EN is defined.
module puf_measure_ctrl
    import puf_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned WIN_W     = WIN_W_DEF,
    parameter int unsigned RESP_BITS = RESP_BITS_DEF,
    parameter int unsigned SEL_W     = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIN_W-1:0]     win_len,
    input  logic [CNT_W-1:0]     cnt_a,
    input  logic [CNT_W-1:0]     cnt_b,
    output logic [SEL_W-1:0]     pair_sel,
    output logic                 cnt_reset,
    output logic                 cnt_enable,
    output logic                 busy,
    output logic                 done,
    output logic [RESP_BITS-1:0] response,
    output logic                 ovf
`ifdef PUF_TIE_FLAG_EN
    ,
    output logic [RESP_BITS-1:0] tie
`endif
);

    state_t                r_state;
    state_t                w_next;
    logic [WIN_W-1:0]      r_len;
    logic [SEL_W-1:0]      r_bit_idx;
    logic [RESP_BITS-1:0]  r_response;
    logic                  r_ovf;
    logic [SEL_W-1:0]      r_pair_sel;
    logic                  r_cnt_reset;
    logic                  r_cnt_enable;
    logic                  r_busy;
    logic                  r_done;
    logic [SEL_W-1:0]      w_pair_sel;
    logic                  w_cnt_reset;
    logic                  w_cnt_enable;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_accept;
    logic                  w_capture;
    logic                  w_last_bit;
    logic                  w_win_last;

    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_capture  = (r_state == ST_CAPTURE);
    assign w_last_bit = (r_bit_idx == SEL_W'(RESP_BITS - 1));

    puf_win_timer #(
        .WIN_W (WIN_W)
    ) u_win_timer (
        .clk   (clk),
        .reset (reset),
        .load  (r_state == ST_CLEAR),
        .len   (r_len),
        .dec   (r_state == ST_RUN),
        .last  (w_win_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_next = ST_CLEAR;
            ST_CLEAR:   w_next = ST_RUN;
            ST_RUN:     if (w_win_last) w_next = ST_SETTLE;
            ST_SETTLE:  w_next = ST_CAPTURE;
            ST_CAPTURE: w_next = w_last_bit ? ST_DONE : ST_CLEAR;
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Outputs are registered copies of the state decode, so the counter view lags the FSM by one cycle.
    always_comb begin
        w_pair_sel   = (r_state == ST_CLEAR) ? r_bit_idx : r_pair_sel;
        w_cnt_reset  = (r_state == ST_CLEAR);
        w_cnt_enable = (r_state == ST_RUN);
        w_busy       = (r_state != ST_IDLE) && (r_state != ST_DONE);
        w_done       = (r_state == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pair_sel   <= '0;
            r_cnt_reset  <= 1'b0;
            r_cnt_enable <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_pair_sel   <= w_pair_sel;
            r_cnt_reset  <= w_cnt_reset;
            r_cnt_enable <= w_cnt_enable;
            r_busy       <= w_busy;
            r_done       <= w_done;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len      <= '0;
            r_bit_idx  <= '0;
            r_response <= '0;
            r_ovf      <= 1'b0;
        end else if (w_accept) begin
            r_len      <= WIN_W'(win_coerce(32'(win_len)));
            r_bit_idx  <= '0;
            r_response <= '0;
            r_ovf      <= 1'b0;
        end else if (w_capture) begin
            r_response[r_bit_idx] <= (cnt_a > cnt_b);
            if ((cnt_a == '1) || (cnt_b == '1)) begin
                r_ovf <= 1'b1;
            end
            if (!w_last_bit) begin
                r_bit_idx <= r_bit_idx + SEL_W'(1);
            end
        end
    end

`ifdef PUF_TIE_FLAG_EN
    logic [RESP_BITS-1:0] r_tie;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tie <= '0;
        end else if (w_accept) begin
            r_tie <= '0;
        end else if (w_capture) begin
            r_tie[r_bit_idx] <= (cnt_a == cnt_b);
        end
    end

    assign tie = r_tie;
`endif

    assign pair_sel   = r_pair_sel;
    assign cnt_reset  = r_cnt_reset;
    assign cnt_enable = r_cnt_enable;
    assign busy       = r_busy;
    assign done       = r_done;
    assign response   = r_response;
    assign ovf        = r_ovf;

endmodule

// File: tb/tb_puf_measure_ctrl.sv
// Directed bench for puf_measure_ctrl with behavioural models of the two external RO counters.
module tb_puf_measure_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] win_len;
    logic [7:0]  cnt_a;
    logic [7:0]  cnt_b;
    logic [2:0]  pair_sel;
    logic        cnt_reset;
    logic        cnt_enable;
    logic        busy;
    logic        done;
    logic [7:0]  response;
    logic        ovf;
`ifdef PUF_TIE_FLAG_EN
    logic [7:0]  tie;
`endif

    puf_measure_ctrl #(
        .CNT_W     (8),
        .WIN_W     (16),
        .RESP_BITS (8),
        .SEL_W     (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .win_len    (win_len),
        .cnt_a      (cnt_a),
        .cnt_b      (cnt_b),
        .pair_sel   (pair_sel),
        .cnt_reset  (cnt_reset),
        .cnt_enable (cnt_enable),
        .busy       (busy),
        .done       (done),
        .response   (response),
        .ovf        (ovf)
`ifdef PUF_TIE_FLAG_EN
        ,
        .tie        (tie)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter models: A counts 2/cycle on pairs flagged in afast, else 1; B the opposite.
    logic [7:0] afast, fix_mask, fix_a, fix_b;
    logic [7:0] m_a, m_b;

    always @(posedge clk) begin
        if (cnt_reset) begin
            m_a <= 8'd0;
            m_b <= 8'd0;
        end else if (cnt_enable) begin
            m_a <= m_a + (afast[pair_sel] ? 8'd2 : 8'd1);
            m_b <= m_b + (afast[pair_sel] ? 8'd1 : 8'd2);
        end
    end

    assign cnt_a = fix_mask[pair_sel] ? fix_a : m_a;
    assign cnt_b = fix_mask[pair_sel] ? fix_b : m_b;

    typedef struct {
        logic [15:0] win;
        logic [7:0]  afast;
        logic [7:0]  fix_mask;
        logic [7:0]  fix_a;
        logic [7:0]  fix_b;
        bit          disturb;
        logic [7:0]  exp_resp;
        logic        exp_ovf;
        logic [7:0]  exp_tie;
        int          exp_done;
        int          exp_en;
    } vec_t;

    vec_t vecs[7];
    int   checks   = 0;
    int   failures = 0;
    localparam int LIMIT = 2000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n, en, rs, ov, extra;
        bit seen;
        @(negedge clk);
        afast    = v.afast;
        fix_mask = v.fix_mask;
        fix_a    = v.fix_a;
        fix_b    = v.fix_b;
        win_len  = v.win;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0; en = 0; rs = 0; ov = 0; seen = 0;
        while (!seen && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                check($sformatf("v%0d busy_after_start", idx), 32'(busy), 32'd1);
                check($sformatf("v%0d cleared_on_start", idx), {23'd0, ovf, response}, 32'd0);
            end
            if (v.disturb && n == 10) begin
                start   = 1'b1;
                win_len = 16'd20;
            end
            if (v.disturb && n == 12) start = 1'b0;
            if (cnt_enable) en++;
            if (cnt_reset) rs++;
            if (cnt_enable && cnt_reset) ov++;
            if (done) seen = 1;
        end
        check($sformatf("v%0d done_cycle", idx), 32'(n), 32'(v.exp_done));
        check($sformatf("v%0d busy_at_done", idx), 32'(busy), 32'd0);
        check($sformatf("v%0d response", idx), 32'(response), 32'(v.exp_resp));
        check($sformatf("v%0d ovf", idx), 32'(ovf), 32'(v.exp_ovf));
        check($sformatf("v%0d enable_cycles", idx), 32'(en), 32'(v.exp_en));
        check($sformatf("v%0d reset_pulses", idx), 32'(rs), 32'd8);
        check($sformatf("v%0d rst_en_overlap", idx), 32'(ov), 32'd0);
`ifdef PUF_TIE_FLAG_EN
        check($sformatf("v%0d tie", idx), 32'(tie), 32'(v.exp_tie));
`endif
        extra = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        check($sformatf("v%0d extra_done", idx), 32'(extra), 32'd0);
        check($sformatf("v%0d hold", idx), {23'd0, ovf, response}, {23'd0, v.exp_ovf, v.exp_resp});
    endtask

    initial begin
        //          win    afast  fmask  fa     fb     dist  resp   ovf   tie    done en
        vecs[0] = '{16'd4,  8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b0, 8'h00, 57,  32};
        vecs[1] = '{16'd10, 8'h55, 8'h00, 8'h00, 8'h00, 1'b0, 8'h55, 1'b0, 8'h00, 105, 80};
        vecs[2] = '{16'd4,  8'hFF, 8'h08, 8'h07, 8'h07, 1'b0, 8'hF7, 1'b0, 8'h08, 57,  32};
        vecs[3] = '{16'd0,  8'h00, 8'h01, 8'hFF, 8'h00, 1'b0, 8'h01, 1'b1, 8'h00, 33,  8};
        vecs[4] = '{16'd7,  8'hA5, 8'h00, 8'h00, 8'h00, 1'b0, 8'hA5, 1'b0, 8'h00, 81,  56};
        vecs[5] = '{16'd2,  8'h0F, 8'h80, 8'h07, 8'h07, 1'b0, 8'h0F, 1'b0, 8'h80, 41,  16};
        vecs[6] = '{16'd4,  8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b0, 8'h00, 57,  32};

        reset = 1'b0; start = 1'b0; win_len = 16'd0;
        afast = 8'h00; fix_mask = 8'h00; fix_a = 8'h00; fix_b = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst pair_sel", 32'(pair_sel), 32'd0);
        check("rst cnt_reset", 32'(cnt_reset), 32'd0);
        check("rst cnt_enable", 32'(cnt_enable), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst response", 32'(response), 32'd0);
        check("rst ovf", 32'(ovf), 32'd0);
`ifdef PUF_TIE_FLAG_EN
        check("rst tie", 32'(tie), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Abort during the window of bit 2; bits 0 and 1 and the ovf flag are already set.
        @(negedge clk);
        afast = 8'hFF; fix_mask = 8'h01; fix_a = 8'hFF; fix_b = 8'h00;
        win_len = 16'd4;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        check("abort pre_response", 32'(response), 32'h03);
        check("abort pre_ovf", 32'(ovf), 32'd1);
        check("abort pre_enable", 32'(cnt_enable), 32'd1);
        check("abort pre_pair_sel", 32'(pair_sel), 32'd2);
        reset = 1'b0;
        #1;
        check("abort enable", 32'(cnt_enable), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort response", 32'(response), 32'd0);
        check("abort ovf", 32'(ovf), 32'd0);
        check("abort pair_sel", 32'(pair_sel), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("abort idle_busy", 32'(busy), 32'd0);
        run_vec(vecs[0], 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
